// File: rtl/frame_loader.sv
// frame_loader: packs 9-bit RGB333 pixels six-per-word and writes one full
// frame into the back RAM bank of the HUB75 driver on each requireData toggle.
`default_nettype none

module frame_loader #(
  parameter int FRAME_WORDS = 3360,
  parameter int ADDR_W      = 12
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_require_data,
  input  logic [8:0]        i_pix_data,
  input  logic              i_pix_valid,
  output logic              o_pix_ready,
  output logic              o_wr,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr_write,
  output logic [53:0]       o_data_line1,
  output logic [53:0]       o_data_line2,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_overrun
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  state_t              state_q, state_d;
  logic                sync1_q, sync2_q, dly_q, req_evt_q;
  logic                pend_q, pend_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   addr_out_q, addr_out_d;
  logic [2:0]          k_q, k_d;
  logic [53:0]         pack_q, pack_d;
  logic [53:0]         line1_q, line1_d;
  logic [53:0]         line2_q, line2_d;
  logic                accept;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      dly_q      <= 1'b0;
      req_evt_q  <= 1'b0;
      pend_q     <= 1'b0;
      state_q    <= S_IDLE;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      addr_out_q <= '0;
      k_q        <= 3'd0;
      pack_q     <= '0;
      line1_q    <= '0;
      line2_q    <= '0;
    end else begin
      sync1_q    <= i_require_data;
      sync2_q    <= sync1_q;
      dly_q      <= sync2_q;
      req_evt_q  <= sync2_q ^ dly_q;
      pend_q     <= pend_d;
      state_q    <= state_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      addr_out_q <= addr_out_d;
      k_q        <= k_d;
      pack_q     <= pack_d;
      line1_q    <= line1_d;
      line2_q    <= line2_d;
    end
  end

  // A request arriving in the same cycle as a pixel restarts the frame, so
  // ready is withheld then to keep the source from losing that pixel.
  assign accept = (state_q == S_FILL) && !req_evt_q && i_pix_valid;

  always_comb begin
    pack_d = pack_q;
    if (accept) begin
      case (k_q)
        3'd0:    pack_d[17:9]  = i_pix_data;
        3'd1:    pack_d[8:0]   = i_pix_data;
        3'd2:    pack_d[35:27] = i_pix_data;
        3'd3:    pack_d[26:18] = i_pix_data;
        3'd4:    pack_d[53:45] = i_pix_data;
        default: pack_d[44:36] = i_pix_data;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_d       = 1'b0;
    wr_d         = wr_q;
    addr_d       = addr_q;
    addr_out_d   = addr_out_q;
    k_d          = k_q;
    line1_d      = line1_q;
    line2_d      = line2_q;
    o_pix_ready  = 1'b0;
    o_we         = 1'b0;
    o_busy       = 1'b0;
    o_frame_done = 1'b0;
    o_overrun    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_evt_q || pend_q) begin
          wr_d    = ~wr_q;
          addr_d  = '0;
          k_d     = 3'd0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        o_busy      = 1'b1;
        o_pix_ready = !req_evt_q;
        if (req_evt_q) begin
          o_overrun = 1'b1;
          wr_d      = ~wr_q;
          addr_d    = '0;
          k_d       = 3'd0;
        end else if (accept) begin
          k_d = k_q + 3'd1;
          if (k_q == 3'd5) begin
            state_d    = S_WRITE;
            addr_out_d = addr_q;
            if (wr_q) line1_d = pack_d;
            else      line2_d = pack_d;
          end
        end
      end
      S_WRITE: begin
        o_busy = 1'b1;
        o_we   = 1'b1;
        if (req_evt_q) begin
          o_overrun = 1'b1;
          wr_d      = ~wr_q;
          addr_d    = '0;
          k_d       = 3'd0;
          state_d   = S_FILL;
        end else if (addr_q == LAST_ADDR) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          k_d     = 3'd0;
          state_d = S_FILL;
        end
      end
      default: begin
        o_busy       = 1'b1;
        o_frame_done = 1'b1;
        pend_d       = req_evt_q;
        state_d      = S_IDLE;
      end
    endcase
  end

  assign o_wr         = wr_q;
  assign o_addr_write = addr_out_q;
  assign o_data_line1 = line1_q;
  assign o_data_line2 = line2_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_loader.sv
// Scoreboard bench for frame_loader: directed pixel words, expected writes
// queued at issue time and checked by an independent write monitor.
`default_nettype none

module tb_frame_loader;

  localparam int FW = 4;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req;
  logic [8:0]    pix;
  logic          pix_valid;
  logic          pix_ready, wr, we, busy, frame_done, overrun;
  logic [AW-1:0] addr;
  logic [53:0]   line1, line2;

  frame_loader #(.FRAME_WORDS(FW), .ADDR_W(AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_require_data(req),
    .i_pix_data(pix), .i_pix_valid(pix_valid), .o_pix_ready(pix_ready),
    .o_wr(wr), .o_we(we), .o_addr_write(addr),
    .o_data_line1(line1), .o_data_line2(line2), .o_busy(busy),
    .o_frame_done(frame_done), .o_overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [53:0]   l1;
    logic [53:0]   l2;
  } exp_t;

  exp_t        sb[$];
  int          we_cyc[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          ovr_cnt = 0;
  logic        prev_we = 1'b0;
  logic        cur_wr = 1'b0;
  logic [53:0] m_l1 = '0;
  logic [53:0] m_l2 = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [53:0] pack6(input logic [8:0] p0, p1, p2, p3, p4, p5);
    return {p4, p5, p2, p3, p0, p1};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      cyc++;
      if (frame_done) done_cnt++;
      if (overrun)    ovr_cnt++;
      if (prev_we) chk("we_single_cycle", {63'd0, we}, 64'd0);
      if (we) begin
        we_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          chk("unexpected_we", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("we_addr",  {52'd0, addr}, {52'd0, e.addr});
          chk("we_bank",  {63'd0, wr},   {63'd0, e.wr});
          chk("we_line1", {10'd0, line1}, {10'd0, e.l1});
          chk("we_line2", {10'd0, line2}, {10'd0, e.l2});
        end
      end
      prev_we = we;
    end
  end

  task automatic push_word(input logic [AW-1:0] a, input logic [53:0] w);
    exp_t e;
    if (cur_wr) m_l1 = w;
    else        m_l2 = w;
    e.wr = cur_wr; e.addr = a; e.l1 = m_l1; e.l2 = m_l2;
    sb.push_back(e);
  endtask

  task automatic send_pix(input logic [8:0] p, input int gap);
    int t = 0;
    pix = p;
    pix_valid = 1'b1;
    while (!pix_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("pix_ready_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    if (gap > 0) begin
      pix_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [AW-1:0] a, input int seed, input int gap);
    logic [8:0] p[6];
    for (int i = 0; i < 6; i++) p[i] = 9'((seed * 37 + i * 83 + 5) % 512);
    push_word(a, pack6(p[0], p[1], p[2], p[3], p[4], p[5]));
    for (int i = 0; i < 6; i++) send_pix(p[i], gap);
  endtask

  task automatic toggle_and_wait;
    int t = 0;
    req = ~req;
    cur_wr = ~cur_wr;
    while (!pix_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 20) chk("start_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_done(input int exp_cnt);
    int t = 0;
    while (done_cnt < exp_cnt && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk("frame_done_count", 64'(done_cnt), 64'(exp_cnt));
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; pix = '0; pix_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr",    {63'd0, wr},        64'd0);
    chk("rst_we",    {63'd0, we},        64'd0);
    chk("rst_ready", {63'd0, pix_ready}, 64'd0);
    chk("rst_busy",  {63'd0, busy},      64'd0);
    chk("rst_addr",  {52'd0, addr},      64'd0);
    chk("rst_line1", {10'd0, line1},     64'd0);
    chk("rst_line2", {10'd0, line2},     64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Frame A: request latency, hand-packed first word, then continuous valid
    req = 1'b1;
    cur_wr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("latency_ready_early", {63'd0, pix_ready}, 64'd0);
    @(posedge clk); #1;
    chk("latency_ready", {63'd0, pix_ready}, 64'd1);
    chk("frameA_wr",     {63'd0, wr},        64'd1);
    m_l1 = {9'h049, 9'h1C0, 9'h124, 9'h092, 9'h1FF, 9'h000};
    begin
      exp_t e;
      e.wr = 1'b1; e.addr = '0; e.l1 = m_l1; e.l2 = '0;
      sb.push_back(e);
    end
    send_pix(9'h1FF, 0); send_pix(9'h000, 0); send_pix(9'h124, 0);
    send_pix(9'h092, 0); send_pix(9'h049, 0); send_pix(9'h1C0, 0);
    for (int w = 1; w < FW; w++) send_word(AW'(w), w, 0);
    pix_valid = 1'b0;
    wait_done(1);
    for (int w = 1; w < FW; w++)
      chk("we_spacing", 64'(we_cyc[w] - we_cyc[w-1]), 64'd7);
    @(posedge clk); #1;
    chk("idle_busy",  {63'd0, busy},      64'd0);
    chk("idle_ready", {63'd0, pix_ready}, 64'd0);

    // Frame B: bank flips, writes land on line2 only
    toggle_and_wait();
    chk("frameB_wr", {63'd0, wr}, 64'd0);
    for (int w = 0; w < FW; w++) send_word(AW'(w), 10 + w, 0);
    pix_valid = 1'b0;
    wait_done(2);

    // Frame C: restart after 2 words + 3 pixels, then throttled valid
    toggle_and_wait();
    send_word(AW'(0), 20, 0);
    send_word(AW'(1), 21, 0);
    send_pix(9'h0AA, 0); send_pix(9'h155, 0); send_pix(9'h033, 0);
    pix_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    req = ~req;
    cur_wr = ~cur_wr;
    begin
      int t = 0;
      while (ovr_cnt < 1 && t < 20) begin
        @(posedge clk); #1;
        t++;
      end
    end
    chk("overrun_count", 64'(ovr_cnt), 64'd1);
    @(posedge clk); #1;
    chk("overrun_wr", {63'd0, wr}, 64'd0);
    for (int w = 0; w < FW; w++) send_word(AW'(w), 30 + w, 2);
    pix_valid = 1'b0;
    wait_done(3);
    chk("overrun_total", 64'(ovr_cnt), 64'd1);

    // Frame D: reset mid-word
    toggle_and_wait();
    send_pix(9'h111, 0); send_pix(9'h022, 0); send_pix(9'h1E1, 0);
    pix_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_wr",    {63'd0, wr},        64'd0);
    chk("midrst_busy",  {63'd0, busy},      64'd0);
    chk("midrst_ready", {63'd0, pix_ready}, 64'd0);
    chk("midrst_addr",  {52'd0, addr},      64'd0);
    chk("midrst_line1", {10'd0, line1},     64'd0);
    chk("midrst_line2", {10'd0, line2},     64'd0);
    chk("sb_empty",     64'(sb.size()),     64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
